snow64_iter_divider: RTL
========================

// Module: snow64_iter_divider
// PURPOSE
// - Parametrised, multi-cycle radix-2 restoring integer divider; scalar successor to the vector div port set.
// - Signed/unsigned; returns quotient, remainder and a divide-by-zero flag.
// - Uses the enable / can_accept_cmd / valid handshake of the mul/div units.
// - Instantiated per lane by the vector divide wrapper; also usable standalone.
// PARAMETERS
// WIDTH  64  operand/result width in bits; legal range 8..64
// CNT_W  $clog2(WIDTH+1)  iteration counter width; derived, do not override
// PORTS
// clk               in   1      clock, all state on rising edge
// rst               in   1      reset, asynchronous, active-high
// in_enable         in   1      command strobe; accepted only when out_can_accept_cmd=1
// in_type_signedness in  1      1 = signed (two's complement), 0 = unsigned
// in_a              in   WIDTH  dividend
// in_b              in   WIDTH  divisor
// out_can_accept_cmd out 1      1 exactly when FSM is IDLE
// out_valid         out  1      one-cycle pulse; results valid this cycle
// out_quot          out  WIDTH  quotient
// out_rem           out  WIDTH  remainder
// out_div_by_zero   out  1      set with out_valid when in_b was 0
// BEHAVIOUR
// - Reset (async, active-high):
//   - FSM=IDLE, out_can_accept_cmd=1
//   - out_valid=0, out_quot=0, out_rem=0, out_div_by_zero=0, all internal regs 0
//   - Reset mid-operation aborts; no valid pulse is produced.
// - FSM states: IDLE -> PREP -> RUN -> FIXUP -> IDLE.
//   - IDLE: on in_enable, capture a, b, signedness.
//   - PREP: take magnitudes if signed and negative; record quotient sign (a^b MSB) and remainder sign (a MSB); clear partial remainder; counter=0.
//   - RUN: WIDTH iterations, one per cycle.
//     - Shift {rem,quot} left 1; trial = rem - |b| (WIDTH+1 bits).
//     - If trial >= 0: rem=trial, quot LSB=1.
//     - Exit to FIXUP when counter reaches WIDTH-1.
//   - FIXUP: negate quot/rem per recorded signs; register out_quot, out_rem, out_div_by_zero; assert out_valid the cycle after.
// - Latency: accept at edge E0 -> out_valid high in the cycle after edge E0+WIDTH+2.
//   - Constant, independent of operand values (no early-out).
// - Results persist until the next FIXUP write; out_valid is high for exactly one cycle.
// - out_valid=1 coincides with IDLE, so in_enable in that same cycle is accepted (back-to-back: one op per WIDTH+3 cycles).
// - in_enable while busy (PREP/RUN/FIXUP) is ignored and not queued; operand inputs are don't-care after acceptance.
// - Divide by zero:
//   - out_quot = all ones, out_rem = in_a, out_div_by_zero=1 (signed or unsigned).
//   - Latency unchanged.
// - Signed overflow (a = most-negative, b = -1):
//   - out_quot = most-negative, out_rem = 0, out_div_by_zero=0.
// - Signed rounding: quotient truncates toward zero; remainder takes the sign of the dividend.
// - Signed magnitude of the most-negative value is held in WIDTH bits as unsigned 2^(WIDTH-1); no extra bit needed.
// TESTING
// 1. WIDTH=64, unsigned 100/7 -> quot=14, rem=2, valid exactly 66 cycles after the accept edge.
// 2. Signed -7/2 -> quot=-3 (0xFFFF_FFFF_FFFF_FFFD), rem=-1; 7/-2 -> quot=-3, rem=1.
// 3. b=0, a=0x1234 (both signednesses) -> quot=0xFFFF_FFFF_FFFF_FFFF, rem=0x1234, div_by_zero=1.
// 4. Signed 0x8000_0000_0000_0000 / -1 -> quot=0x8000_0000_0000_0000, rem=0; unsigned same operands -> quot=0, rem=0x8000_0000_0000_0000.
// 5. Handshake, WIDTH=8:
//    - Issue 200/3 unsigned; pulse in_enable mid-RUN -> ignored (single valid, quot=66, rem=2).
//    - New cmd in the valid cycle -> accepted; its valid arrives 10 cycles later.
// 6. Assert rst during RUN -> outputs go to 0 asynchronously, can_accept=1, no valid; a following 9/3 returns quot=3, rem=0.

Source files
------------

// File: rtl/snow64_iter_divider.sv
`default_nettype none
// ============================================================================
// Module      : snow64_iter_divider
// Description : Multi-cycle radix-2 restoring integer divider, signed or
//               unsigned, with quotient, remainder and divide-by-zero flag.
// Revision    : 1.0 - initial release
// ============================================================================
module snow64_iter_divider #(
  parameter int WIDTH = 64,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_enable,
  input  logic             in_type_signedness,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_can_accept_cmd,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_quot,
  output logic [WIDTH-1:0] out_rem,
  output logic             out_div_by_zero
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PREP  = 2'd1,
    ST_RUN   = 2'd2,
    ST_FIXUP = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] c_last    = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);

  state_t           r_state;
  state_t           w_next;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_signed;
  logic [WIDTH-1:0] r_b_mag;
  logic [WIDTH-1:0] r_quot;
  logic [WIDTH-1:0] r_rem;
  logic [CNT_W-1:0] r_cnt;
  logic             r_q_neg;
  logic             r_r_neg;

  logic             w_a_neg;
  logic             w_b_neg;
  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_trial;
  logic [WIDTH-1:0] w_q_next;
  logic [WIDTH-1:0] w_r_next;
  logic [WIDTH-1:0] w_q_fix;
  logic [WIDTH-1:0] w_r_fix;
  logic             w_dbz;

  assign out_can_accept_cmd = (r_state == ST_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (in_enable) w_next = ST_PREP;
      ST_PREP:  w_next = ST_RUN;
      ST_RUN:   if (r_cnt == c_last) w_next = ST_FIXUP;
      ST_FIXUP: w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  // The most-negative value negates to itself, which read as unsigned is 2^(WIDTH-1).
  assign w_a_neg = r_signed & r_a[WIDTH-1];
  assign w_b_neg = r_signed & r_b[WIDTH-1];
  assign w_a_mag = w_a_neg ? (-r_a) : r_a;
  assign w_b_mag = w_b_neg ? (-r_b) : r_b;

  // Partial remainder stays below the divisor, so WIDTH+1 signed bits hold the trial.
  assign w_shift  = {r_rem, r_quot[WIDTH-1]};
  assign w_trial  = w_shift - {1'b0, r_b_mag};
  assign w_q_next = {r_quot[WIDTH-2:0], ~w_trial[WIDTH]};
  assign w_r_next = w_trial[WIDTH] ? w_shift[WIDTH-1:0] : w_trial[WIDTH-1:0];

  assign w_q_fix = r_q_neg ? (-r_quot) : r_quot;
  assign w_r_fix = r_r_neg ? (-r_rem) : r_rem;
  assign w_dbz   = (r_b == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a             <= '0;
      r_b             <= '0;
      r_signed        <= 1'b0;
      r_b_mag         <= '0;
      r_quot          <= '0;
      r_rem           <= '0;
      r_cnt           <= '0;
      r_q_neg         <= 1'b0;
      r_r_neg         <= 1'b0;
      out_valid       <= 1'b0;
      out_quot        <= '0;
      out_rem         <= '0;
      out_div_by_zero <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (in_enable) begin
            r_a      <= in_a;
            r_b      <= in_b;
            r_signed <= in_type_signedness;
          end
        end
        ST_PREP: begin
          r_b_mag <= w_b_mag;
          r_quot  <= w_a_mag;
          r_rem   <= '0;
          r_cnt   <= '0;
          r_q_neg <= w_a_neg ^ w_b_neg;
          r_r_neg <= w_a_neg;
        end
        ST_RUN: begin
          r_quot <= w_q_next;
          r_rem  <= w_r_next;
          r_cnt  <= r_cnt + c_cnt_one;
        end
        ST_FIXUP: begin
          // Divide-by-zero reports the raw dividend, not the iterated remainder.
          out_quot        <= w_dbz ? '1 : w_q_fix;
          out_rem         <= w_dbz ? r_a : w_r_fix;
          out_div_by_zero <= w_dbz;
          out_valid       <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire
